// File: rtl/instr_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// instr_prefetch_buffer
//
// Byte-granular instruction prefetch queue feeding the fetch stage. A circular
// byte buffer is filled from instruction memory with 8-byte reads starting at
// fill_pc, and fetch sees a 10-byte window beginning at win_pc (long enough
// for the longest Y86-64 instruction). Fetch retires 1..10 bytes per cycle; a
// redirect flushes everything and restarts filling at redirect_pc.
//
// Ports:
//   clk          : rising-edge clock
//   reset        : asynchronous, active-high reset
//   redirect     : flush queue and restart at redirect_pc
//   redirect_pc  : new fetch PC
//   consume      : fetch retires consume_len bytes this cycle
//   consume_len  : bytes to retire (legal 1..win_count)
//   win_bytes    : window bytes, byte k at [8k+7:8k]
//   win_count    : number of valid window bytes, min(occupancy, 10)
//   win_pc       : address of window byte 0
//   win_err      : a memory fault lies just past the valid bytes
//   mem_req      : memory read request
//   mem_addr     : byte address of the 8-byte read
//   mem_ack      : request accepted, data valid this cycle
//   mem_data     : read data, byte at mem_addr in [7:0]
//   mem_err      : qualifies mem_ack, the read faulted
// -----------------------------------------------------------------------------
module instr_prefetch_buffer #(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  input  logic        consume,
  input  logic [3:0]  consume_len,
  output logic [79:0] win_bytes,
  output logic [3:0]  win_count,
  output logic [63:0] win_pc,
  output logic        win_err,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [63:0] mem_data,
  input  logic        mem_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD,
    HALT
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      buf_q [DEPTH];
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [AW:0]     occ_q, occ_d;
  logic [63:0]     fill_pc_q, fill_pc_d;
  logic [63:0]     win_pc_q, win_pc_d;
  logic [63:0]     req_addr_q, req_addr_d;
  logic            err_q, err_d;
  logic            consume_ok;
  logic            fill_ok;
  logic            has_room;

  // The window count saturates at 10; it is the only gate fetch needs to
  // decide how many bytes it may retire.
  always_comb begin
    if (occ_q >= (AW+1)'(10)) begin
      win_count = 4'd10;
    end else begin
      win_count = occ_q[3:0];
    end
  end

  // The window is a straight combinational view of storage starting at the
  // head pointer; the AW-bit index wraps naturally past the end of the buffer.
  for (genvar k = 0; k < 10; k++) begin : g_win
    assign win_bytes[8*k +: 8] = buf_q[head_q + AW'(k)];
  end

  // Accept/write qualifiers. A consume longer than win_count (which also
  // covers anything above 10) or of length 0 is simply ignored. A redirect
  // beats both consume and fill, so a same-cycle ack is dropped.
  always_comb begin
    consume_ok = consume && (consume_len != 4'd0) && (consume_len <= win_count) && !redirect;
    fill_ok    = (state_q == REQ) && mem_ack && !mem_err && !redirect;
    has_room   = occ_q <= (AW+1)'(DEPTH - 8);
  end

  // Request interface. mem_addr comes from a register captured when the
  // request is launched, so it stays put through DISCARD even though a
  // redirect has already moved fill_pc.
  always_comb begin
    mem_req  = (state_q == REQ) || (state_q == DISCARD);
    mem_addr = mem_req ? req_addr_q : 64'd0;
    win_pc   = win_pc_q;
    win_err  = err_q && (win_count < 4'd10);
  end

  // Next-state logic: pointer/occupancy arithmetic first (consume and fill
  // both contribute), then the FSM, then the redirect override which wipes
  // the queue and clears the error latch last so it always wins.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    fill_pc_d  = fill_pc_q;
    win_pc_d   = win_pc_q;
    req_addr_d = req_addr_q;
    err_d      = err_q;

    if (consume_ok) begin
      head_d   = head_q + AW'(consume_len);
      occ_d    = occ_d - (AW+1)'(consume_len);
      win_pc_d = win_pc_q + 64'(consume_len);
    end

    if (fill_ok) begin
      tail_d    = tail_q + AW'(8);
      occ_d     = occ_d + (AW+1)'(8);
      fill_pc_d = fill_pc_q + 64'd8;
    end

    case (state_q)
      IDLE: begin
        if (!redirect && !err_q && has_room) begin
          state_d    = REQ;
          req_addr_d = fill_pc_q;
        end
      end
      REQ: begin
        if (mem_ack) begin
          if (!redirect && mem_err) begin
            err_d   = 1'b1;
            state_d = HALT;
          end else begin
            state_d = IDLE;
          end
        end else if (redirect) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        // The stale response is dropped whenever it shows up; a further
        // redirect while waiting changes nothing about that.
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      HALT: begin
        if (redirect) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect) begin
      occ_d     = '0;
      head_d    = '0;
      tail_d    = '0;
      win_pc_d  = redirect_pc;
      fill_pc_d = redirect_pc;
      err_d     = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      fill_pc_q  <= '0;
      win_pc_q   <= '0;
      req_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      fill_pc_q  <= fill_pc_d;
      win_pc_q   <= win_pc_d;
      req_addr_q <= req_addr_d;
      err_q      <= err_d;
    end
  end

  // Byte storage. An accepted fill writes 8 consecutive bytes at tail, each
  // index wrapping independently so a write may straddle the buffer end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= 8'd0;
      end
    end else if (fill_ok) begin
      for (int i = 0; i < 8; i++) begin
        buf_q[tail_q + AW'(i)] <= mem_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_instr_prefetch_buffer
//
// Directed testbench for instr_prefetch_buffer. Memory content is modelled as
// byte value = address[7:0], so every window byte can be predicted from the
// address the bench expects it to come from.
// -----------------------------------------------------------------------------
module tb_instr_prefetch_buffer;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        consume;
  logic [3:0]  consume_len;
  logic [79:0] win_bytes;
  logic [3:0]  win_count;
  logic [63:0] win_pc;
  logic        win_err;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [63:0] mem_data;
  logic        mem_err;

  int          passCount;
  int          failCount;
  int          totalCount;
  logic        autoAck;
  logic [63:0] ackLog[$];

  instr_prefetch_buffer #(.DEPTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .consume     (consume),
    .consume_len (consume_len),
    .win_bytes   (win_bytes),
    .win_count   (win_count),
    .win_pc      (win_pc),
    .win_err     (win_err),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .mem_err     (mem_err)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: each byte holds the low 8 bits of its own address.
  function automatic logic [63:0] memWord(input logic [63:0] a);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) begin
      w[8*i +: 8] = 8'(a + 64'(i));
    end
    return w;
  endfunction

  // Compare one observed value against its expected value and tally it.
  task automatic checkOutput(input string tag, input logic [79:0] observed, input logic [79:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock. With autoAck set, any pending request is answered in
  // the same cycle from the memory image. One-cycle pulses are cleared after
  // the edge, and outputs are then sampled 1 time unit past the edge.
  task automatic applyStimulus();
    if (autoAck) begin
      mem_ack  = mem_req;
      mem_err  = 1'b0;
      mem_data = memWord(mem_addr);
    end
    if (mem_req && mem_ack) ackLog.push_back(mem_addr);
    @(posedge clk);
    #1;
    consume     = 1'b0;
    consume_len = 4'd0;
    redirect    = 1'b0;
    if (!autoAck) begin
      mem_ack  = 1'b0;
      mem_err  = 1'b0;
      mem_data = 64'd0;
    end
  endtask

  // From an IDLE cycle: let the request launch, check its address, ack it.
  task automatic fillOne(input logic [63:0] addr);
    applyStimulus();
    checkOutput("fill_req", mem_req, 1'b1);
    checkOutput("fill_addr", mem_addr, addr);
    mem_ack  = 1'b1;
    mem_data = memWord(addr);
    applyStimulus();
  endtask

  // Directed sequence covering reset, steady fill, streaming consume with
  // wrap, redirect/discard, simultaneous consume+fill, faults, illegal lengths.
  initial begin
    int          pat[4];
    int          p;
    int          consumed;
    logic [63:0] expPc;

    passCount   = 0;
    failCount   = 0;
    totalCount  = 0;
    autoAck     = 1'b0;
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 64'd0;
    consume     = 1'b0;
    consume_len = 4'd0;
    mem_ack     = 1'b0;
    mem_data    = 64'd0;
    mem_err     = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_mem_req", mem_req, 1'b0);
    checkOutput("rst_mem_addr", mem_addr, 64'd0);
    checkOutput("rst_win_count", win_count, 4'd0);
    checkOutput("rst_win_pc", win_pc, 64'd0);
    checkOutput("rst_win_err", win_err, 1'b0);
    checkOutput("rst_win_bytes", win_bytes, 80'd0);
    reset = 1'b0;

    $display("[TB] fill after reset");
    checkOutput("c0_mem_req", mem_req, 1'b0);
    autoAck = 1'b1;
    applyStimulus();
    checkOutput("c1_mem_req", mem_req, 1'b1);
    checkOutput("c1_mem_addr", mem_addr, 64'd0);
    repeat (11) applyStimulus();
    checkOutput("fill_ack_count", ackLog.size(), 4);
    checkOutput("fill_addr0", ackLog[0], 64'd0);
    checkOutput("fill_addr1", ackLog[1], 64'd8);
    checkOutput("fill_addr2", ackLog[2], 64'd16);
    checkOutput("fill_addr3", ackLog[3], 64'd24);
    checkOutput("full_no_req", mem_req, 1'b0);
    checkOutput("full_win_count", win_count, 4'd10);
    checkOutput("full_win_pc", win_pc, 64'd0);
    checkOutput("full_win_bytes", win_bytes, 80'h09080706050403020100);

    $display("[TB] streaming consume with wrap");
    pat      = '{10, 1, 9, 2};
    p        = 0;
    consumed = 0;
    expPc    = 64'd0;
    for (int c = 0; c < 80; c++) begin
      checkOutput("stream_pc", win_pc, expPc);
      for (int k = 0; k < int'(win_count); k++) begin
        checkOutput("stream_byte", win_bytes[8*k +: 8], 8'(expPc + 64'(k)));
      end
      if (int'(win_count) >= pat[p]) begin
        consume     = 1'b1;
        consume_len = 4'(pat[p]);
        expPc       = expPc + 64'(pat[p]);
        consumed    = consumed + pat[p];
        p           = (p + 1) % 4;
      end
      applyStimulus();
    end
    checkOutput("stream_progress", consumed >= 100, 1'b1);

    $display("[TB] redirect and discard");
    redirect    = 1'b1;
    redirect_pc = 64'h200;
    applyStimulus();
    autoAck = 1'b0;
    checkOutput("rd1_win_count", win_count, 4'd0);
    checkOutput("rd1_win_pc", win_pc, 64'h200);
    checkOutput("rd1_mem_req", mem_req, 1'b0);
    applyStimulus();
    checkOutput("rd1_req", mem_req, 1'b1);
    checkOutput("rd1_addr", mem_addr, 64'h200);
    redirect    = 1'b1;
    redirect_pc = 64'h100;
    applyStimulus();
    checkOutput("disc_req", mem_req, 1'b1);
    checkOutput("disc_addr", mem_addr, 64'h200);
    checkOutput("disc_win_pc", win_pc, 64'h100);
    checkOutput("disc_win_count", win_count, 4'd0);
    applyStimulus();
    applyStimulus();
    mem_ack  = 1'b1;
    mem_data = 64'hFFFF_FFFF_FFFF_FFFF;
    applyStimulus();
    checkOutput("disc_drop_count", win_count, 4'd0);
    checkOutput("disc_drop_req", mem_req, 1'b0);
    fillOne(64'h100);
    checkOutput("new_win_count", win_count, 4'd8);
    checkOutput("new_win_pc", win_pc, 64'h100);
    checkOutput("new_win_bytes", win_bytes[63:0], 64'h0706050403020100);

    $display("[TB] consume and fill in the same cycle");
    applyStimulus();
    checkOutput("cf_addr", mem_addr, 64'h108);
    consume     = 1'b1;
    consume_len = 4'd3;
    mem_ack     = 1'b1;
    mem_data    = memWord(64'h108);
    applyStimulus();
    checkOutput("cf_win_count", win_count, 4'd10);
    checkOutput("cf_win_pc", win_pc, 64'h103);
    checkOutput("cf_win_bytes", win_bytes, 80'h0C0B0A09080706050403);
    consume     = 1'b1;
    consume_len = 4'd10;
    applyStimulus();
    checkOutput("cf_rem_count", win_count, 4'd3);
    checkOutput("cf_rem_pc", win_pc, 64'h10D);
    checkOutput("cf_next_addr", mem_addr, 64'h110);

    $display("[TB] illegal consume lengths");
    consume     = 1'b1;
    consume_len = 4'd5;
    applyStimulus();
    checkOutput("ill5_win_pc", win_pc, 64'h10D);
    checkOutput("ill5_win_count", win_count, 4'd3);
    consume     = 1'b1;
    consume_len = 4'd0;
    applyStimulus();
    checkOutput("ill0_win_pc", win_pc, 64'h10D);
    checkOutput("ill0_win_count", win_count, 4'd3);
    mem_ack  = 1'b1;
    mem_data = memWord(64'h110);
    applyStimulus();
    checkOutput("ill_fill_count", win_count, 4'd10);
    consume     = 1'b1;
    consume_len = 4'd11;
    applyStimulus();
    checkOutput("ill11_win_pc", win_pc, 64'h10D);
    checkOutput("ill11_win_count", win_count, 4'd10);
    checkOutput("ill11_win_bytes", win_bytes, 80'h161514131211100F0E0D);

    $display("[TB] memory fault");
    redirect    = 1'b1;
    redirect_pc = 64'd0;
    mem_ack     = 1'b1;
    mem_data    = 64'hFFFF_FFFF_FFFF_FFFF;
    applyStimulus();
    checkOutput("err_rd_count", win_count, 4'd0);
    checkOutput("err_rd_pc", win_pc, 64'd0);
    checkOutput("err_rd_req", mem_req, 1'b0);
    fillOne(64'h00);
    fillOne(64'h08);
    fillOne(64'h10);
    applyStimulus();
    checkOutput("err_req_addr", mem_addr, 64'h18);
    mem_ack  = 1'b1;
    mem_err  = 1'b1;
    mem_data = 64'hFFFF_FFFF_FFFF_FFFF;
    applyStimulus();
    checkOutput("halt_req", mem_req, 1'b0);
    checkOutput("halt_count", win_count, 4'd10);
    checkOutput("halt_err_hidden", win_err, 1'b0);
    consume     = 1'b1;
    consume_len = 4'd10;
    applyStimulus();
    checkOutput("halt_c10_count", win_count, 4'd10);
    checkOutput("halt_c10_err", win_err, 1'b0);
    consume     = 1'b1;
    consume_len = 4'd6;
    applyStimulus();
    checkOutput("halt_c6_count", win_count, 4'd8);
    checkOutput("halt_c6_pc", win_pc, 64'h10);
    checkOutput("halt_c6_err", win_err, 1'b1);
    checkOutput("halt_c6_bytes", win_bytes[63:0], 64'h1716151413121110);
    for (int c = 0; c < 5; c++) begin
      applyStimulus();
      checkOutput("halt_idle_req", mem_req, 1'b0);
      checkOutput("halt_idle_err", win_err, 1'b1);
    end
    redirect    = 1'b1;
    redirect_pc = 64'd0;
    applyStimulus();
    checkOutput("clr_err", win_err, 1'b0);
    checkOutput("clr_count", win_count, 4'd0);
    applyStimulus();
    checkOutput("resume_req", mem_req, 1'b1);
    checkOutput("resume_addr", mem_addr, 64'd0);

    $display("[TB] %0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
